// File: rtl/go_frame_pkg.sv
// Shared types and constants for the go frame assembler.
// A beat is shaped like one element of the consumer's go input
// ([0:3][0:2][3:3], 12 bits). A frame is three such beats as go [2:0].
// Beat 0 of a frame lands in go[2], so it sits in the top bits of a packed frame.
package go_frame_pkg;

  localparam int BEATS  = 3;
  localparam int BEAT_W = 12;
  localparam int TS_W   = 64;

  typedef logic [0:3][0:2][3:3] go_beat_t;
  typedef go_beat_t go_frame_t [2:0];

  typedef enum logic [1:0] {FILL, STALL, DISCARD} asm_state_e;

  // Flatten a frame so that go[2] (beat 0) occupies the most significant bits.
  function automatic logic [BEATS*BEAT_W-1:0] pack_frame(input go_frame_t f);
    return {f[2], f[1], f[0]};
  endfunction

endpackage

// File: rtl/go_ts_counter.sv
// Free-running cycle counter used to timestamp frames.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset, clears the count
//   ts  - current count, increments every non-reset cycle and wraps
module go_ts_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] ts
);

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + WIDTH'(1);
  end

endmodule

// File: rtl/go_frame_assembler.sv
// Collects 12-bit beats from a valid/ready stream and assembles each group
// of three into one go-shaped frame, timestamped at beat 0 acceptance.
// Short frames are zero padded, long frames are truncated; both raise err.
// One output register sits beyond the staging array.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   in_valid/in_ready      - beat handshake; in_ready depends on state only
//   in_data, in_last       - beat payload (4-state carried through), end of frame
//   out_valid/out_ready    - frame handshake
//   out_go                 - frame, [35:24]=beat 0 ... [11:0]=beat 2
//   out_ts                 - cycle count at acceptance of beat 0
//   out_xz                 - any X/Z bit in out_go
//   out_err                - frame was short or long
//   frame_cnt              - number of output handshakes, wraps
module go_frame_assembler
  import go_frame_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BEAT_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BEATS*BEAT_W-1:0] out_go,
  output logic [TS_W-1:0]         out_ts,
  output logic                    out_xz,
  output logic                    out_err,
  output logic [CNT_W-1:0]        frame_cnt
);

  logic [TS_W-1:0] cyc;

  go_ts_counter #(.WIDTH(TS_W)) u_ts (
    .clk (clk),
    .rst (rst),
    .ts  (cyc)
  );

  asm_state_e state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic       disc_pend, disc_pend_nxt;

  go_frame_t       stage_p0;
  logic [TS_W-1:0] stage_ts_p0;
  logic            stage_err_p0;

  go_frame_t       frame_c;
  logic [TS_W-1:0] ts_c;
  logic            err_c;

  logic acc, fill_acc, complete, is_long, out_free, hs, load_new, load_stall;

  assign in_ready   = (state != STALL);
  assign acc        = in_valid && in_ready;
  assign fill_acc   = acc && (state == FILL);
  assign complete   = fill_acc && (in_last || idx == 2'd2);
  assign is_long    = fill_acc && (idx == 2'd2) && !in_last;
  assign hs         = out_valid && out_ready;
  assign out_free   = !out_valid || out_ready;
  assign load_new   = complete && out_free;
  assign load_stall = (state == STALL) && out_ready;

  // Frame as it would look if completed this cycle: earlier slots from the
  // staging array, the current beat in its slot, later slots zero (padding).
  always_comb begin
    for (int k = 0; k < BEATS; k++) begin
      if (k < int'(idx))       frame_c[BEATS-1-k] = stage_p0[BEATS-1-k];
      else if (k == int'(idx)) frame_c[BEATS-1-k] = go_beat_t'(in_data);
      else                     frame_c[BEATS-1-k] = '0;
    end
    ts_c  = (idx == 2'd0) ? cyc : stage_ts_p0;
    err_c = is_long || (in_last && idx != 2'd2);
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    disc_pend_nxt = disc_pend;
    unique case (state)
      FILL: begin
        if (fill_acc) begin
          if (complete) begin
            idx_nxt = 2'd0;
            if (out_free) begin
              state_nxt = is_long ? DISCARD : FILL;
            end else begin
              state_nxt     = STALL;
              disc_pend_nxt = is_long;
            end
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      STALL: begin
        if (out_ready) begin
          state_nxt     = disc_pend ? DISCARD : FILL;
          disc_pend_nxt = 1'b0;
        end
      end
      DISCARD: begin
        if (acc && in_last) begin
          state_nxt = FILL;
          idx_nxt   = 2'd0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= 2'd0;
      disc_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      disc_pend <= disc_pend_nxt;
    end
  end

  // Stage p0: staging array, written on every beat accepted while filling.
  always_ff @(posedge clk) begin
    if (fill_acc) begin
      stage_p0     <= frame_c;
      stage_ts_p0  <= ts_c;
      stage_err_p0 <= err_c;
    end
  end

  // Stage p1: output register, loaded directly on completion or from staging.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_go    <= '0;
      out_ts    <= '0;
      out_xz    <= 1'b0;
      out_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (hs) frame_cnt <= frame_cnt + CNT_W'(1);
      if (load_new) begin
        out_valid <= 1'b1;
        out_go    <= pack_frame(frame_c);
        out_ts    <= ts_c;
        out_err   <= err_c;
        out_xz    <= $isunknown(pack_frame(frame_c));
      end else if (load_stall) begin
        out_valid <= 1'b1;
        out_go    <= pack_frame(stage_p0);
        out_ts    <= stage_ts_p0;
        out_err   <= stage_err_p0;
        out_xz    <= $isunknown(pack_frame(stage_p0));
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_go_frame_assembler.sv
module tb_go_frame_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_go;
  logic [63:0] out_ts;
  logic        out_xz;
  logic        out_err;
  logic [15:0] frame_cnt;

  go_frame_assembler #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_go    (out_go),
    .out_ts    (out_ts),
    .out_xz    (out_xz),
    .out_err   (out_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        vld;
    logic [11:0] d;
    logic        last;
    logic        e_ov;
    logic [15:0] e_cnt;
    logic        chkf;
    logic [35:0] e_go;
    logic        e_err;
    logic [63:0] e_ts;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mv(input logic v, input logic [11:0] d, input logic l,
                              input logic ov, input logic [15:0] c, input logic f,
                              input logic [35:0] go, input logic err, input logic [63:0] ts);
    vec_t r;
    r.vld = v; r.d = d; r.last = l; r.e_ov = ov; r.e_cnt = c;
    r.chkf = f; r.e_go = go; r.e_err = err; r.e_ts = ts;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [11:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string nm, input logic ov, input logic ir, input logic [15:0] c);
    chk({nm, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
    chk({nm, ".in_ready"},  {63'd0, in_ready},  {63'd0, ir});
    chk({nm, ".frame_cnt"}, {48'd0, frame_cnt}, {48'd0, c});
  endtask

  task automatic chk_frm(input string nm, input logic [35:0] go, input logic err, input logic xz);
    chk({nm, ".out_go"},  {28'd0, out_go},  {28'd0, go});
    chk({nm, ".out_err"}, {63'd0, out_err}, {63'd0, err});
    chk({nm, ".out_xz"},  {63'd0, out_xz},  {63'd0, xz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  logic [15:0] ec;
  logic [11:0] xzv;
  logic [35:0] egx;

  initial begin
    // Beat 0 accepted in the first cycle after reset sees count 0.
    tbl[0]  = mv(1, 12'h111, 0, 0, 0, 0, 36'h0,         0, 0);
    tbl[1]  = mv(1, 12'h222, 0, 0, 0, 0, 36'h0,         0, 0);
    tbl[2]  = mv(1, 12'h333, 1, 1, 0, 1, 36'h111222333, 0, 0);
    tbl[3]  = mv(1, 12'h444, 0, 0, 1, 0, 36'h0,         0, 0);
    tbl[4]  = mv(1, 12'h555, 0, 0, 1, 0, 36'h0,         0, 0);
    tbl[5]  = mv(1, 12'h666, 1, 1, 1, 1, 36'h444555666, 0, 3);
    tbl[6]  = mv(0, 12'h000, 0, 0, 2, 0, 36'h0,         0, 0);
    tbl[7]  = mv(1, 12'hABC, 0, 0, 2, 0, 36'h0,         0, 0);
    tbl[8]  = mv(1, 12'hDEF, 1, 1, 2, 1, 36'hABCDEF000, 1, 7);
    tbl[9]  = mv(0, 12'h000, 0, 0, 3, 0, 36'h0,         0, 0);
    tbl[10] = mv(1, 12'h001, 0, 0, 3, 0, 36'h0,         0, 0);
    tbl[11] = mv(1, 12'h002, 0, 0, 3, 0, 36'h0,         0, 0);
    tbl[12] = mv(1, 12'h003, 0, 1, 3, 1, 36'h001002003, 1, 10);
    tbl[13] = mv(1, 12'h004, 0, 0, 4, 0, 36'h0,         0, 0);
    tbl[14] = mv(1, 12'h005, 1, 0, 4, 0, 36'h0,         0, 0);
    tbl[15] = mv(1, 12'h00A, 0, 0, 4, 0, 36'h0,         0, 0);
    tbl[16] = mv(1, 12'h00B, 0, 0, 4, 0, 36'h0,         0, 0);
    tbl[17] = mv(1, 12'h00C, 1, 1, 4, 1, 36'h00A00B00C, 0, 15);
    tbl[18] = mv(0, 12'h000, 0, 0, 5, 0, 36'h0,         0, 0);

    rst = 1'b1;
    tick(0, 12'h0, 0, 1);
    tick(0, 12'h0, 0, 1);
    chk_ctl("reset", 0, 1, 0);
    chk_frm("reset", 36'h0, 0, 0);
    chk("reset.out_ts", out_ts, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].vld, tbl[i].d, tbl[i].last, 1'b1);
      chk_ctl($sformatf("vec%0d", i), tbl[i].e_ov, 1'b1, tbl[i].e_cnt);
      if (tbl[i].chkf) begin
        chk_frm($sformatf("vec%0d", i), tbl[i].e_go, tbl[i].e_err, 1'b0);
        chk($sformatf("vec%0d.out_ts", i), out_ts, tbl[i].e_ts);
      end
    end
    ec = 16'd5;

    // Backpressure: two frames against a stalled consumer for 10 cycles.
    tick(1, 12'hB01, 0, 0);
    tick(1, 12'hB02, 0, 0);
    tick(1, 12'hB03, 1, 0);
    chk_ctl("bp_a", 1, 1, ec);
    chk_frm("bp_a", 36'hB01B02B03, 0, 0);
    tick(1, 12'hB04, 0, 0);
    tick(1, 12'hB05, 0, 0);
    tick(1, 12'hB06, 1, 0);
    chk_ctl("bp_stall", 1, 0, ec);
    for (int i = 0; i < 4; i++) begin
      tick(0, 12'h0, 0, 0);
      chk_ctl($sformatf("bp_hold%0d", i), 1, 0, ec);
      chk($sformatf("bp_hold%0d.out_go", i), {28'd0, out_go}, {28'd0, 36'hB01B02B03});
    end
    tick(0, 12'h0, 0, 1);
    ec++;
    chk_ctl("bp_rel", 1, 1, ec);
    chk_frm("bp_rel", 36'hB04B05B06, 0, 0);
    tick(0, 12'h0, 0, 1);
    ec++;
    chk_ctl("bp_done", 0, 1, ec);

    // Handshake and completion in the same cycle.
    tick(1, 12'hC01, 0, 0);
    tick(1, 12'hC02, 0, 0);
    tick(1, 12'hC03, 1, 0);
    chk_frm("sim_a", 36'hC01C02C03, 0, 0);
    tick(1, 12'hC04, 0, 0);
    tick(1, 12'hC05, 0, 0);
    tick(1, 12'hC06, 1, 1);
    ec++;
    chk_ctl("sim_b", 1, 1, ec);
    chk_frm("sim_b", 36'hC04C05C06, 0, 0);
    tick(0, 12'h0, 0, 1);
    ec++;
    chk_ctl("sim_done", 0, 1, ec);

    // Long frame that stalls: discard must still follow the release.
    tick(1, 12'hD01, 0, 0);
    tick(1, 12'hD02, 0, 0);
    tick(1, 12'hD03, 1, 0);
    tick(1, 12'hD04, 0, 0);
    tick(1, 12'hD05, 0, 0);
    tick(1, 12'hD06, 0, 0);
    chk_ctl("lst_stall", 1, 0, ec);
    tick(0, 12'h0, 0, 1);
    ec++;
    chk_ctl("lst_rel", 1, 1, ec);
    chk_frm("lst_rel", 36'hD04D05D06, 1, 0);
    tick(1, 12'hD07, 0, 1);
    ec++;
    chk_ctl("lst_drop1", 0, 1, ec);
    tick(1, 12'hD08, 1, 1);
    chk_ctl("lst_drop2", 0, 1, ec);
    tick(1, 12'hE01, 0, 1);
    tick(1, 12'hE02, 0, 1);
    tick(1, 12'hE03, 1, 1);
    chk_ctl("lst_next", 1, 1, ec);
    chk_frm("lst_next", 36'hE01E02E03, 0, 0);
    tick(0, 12'h0, 0, 1);
    ec++;

    // X/Z content is carried through and flagged.
    xzv = 12'b0000_x000_z000;
    egx = {12'h123, xzv, 12'h456};
    tick(1, 12'h123, 0, 1);
    tick(1, xzv, 0, 1);
    tick(1, 12'h456, 1, 1);
    chk("xz.out_go", {28'd0, out_go}, {28'd0, egx});
    chk("xz.out_xz", {63'd0, out_xz}, {63'd0, $isunknown(egx)});
    tick(0, 12'h0, 0, 1);
    ec++;
    tick(1, 12'hFFF, 0, 1);
    tick(1, 12'h000, 0, 1);
    tick(1, 12'h5A5, 1, 1);
    chk_ctl("clean", 1, 1, ec);
    chk_frm("clean", 36'hFFF0005A5, 0, 0);
    tick(0, 12'h0, 0, 1);

    // Reset mid-frame drops the partial frame.
    tick(1, 12'h701, 0, 1);
    tick(1, 12'h702, 0, 1);
    rst = 1'b1;
    tick(0, 12'h0, 0, 1);
    rst = 1'b0;
    chk_ctl("mrst", 0, 1, 0);
    tick(1, 12'h777, 0, 1);
    tick(1, 12'h888, 0, 1);
    tick(1, 12'h999, 1, 1);
    chk_ctl("mrst_f", 1, 1, 0);
    chk_frm("mrst_f", 36'h777888999, 0, 0);
    chk("mrst_f.out_ts", out_ts, 64'd0);
    tick(0, 12'h0, 0, 1);
    chk_ctl("mrst_done", 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/go_frame_assembler.md
Name: go_frame_assembler

Overview:
- Upstream stage of the fwll consumer: collects 12-bit 4-state beats over a valid/ready stream and assembles each group of three into one frame shaped as fwll's go input (reg [0:3][0:2][3:3] go [2:0]).
- Stamps each frame with a 64-bit time value for the consumer's time-typed path.
- Flags X/Z content and malformed frames.
- Presents frames through a registered valid/ready output with one frame of buffering beyond the staging array.

Parameters:
BEATS, 3, beats per frame (fixed at 3 to match go [2:0]).
BEAT_W, 12, bits per beat (4*3*1, matching [0:3][0:2][3:3]).
TS_W, 64, timestamp width (time).
CNT_W, 16, delivered-frame counter width.

Ports:
clk  input  1  single clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  beat offered.
in_ready  output  1  beat accepted when in_valid && in_ready.
in_data  input  BEAT_W  beat payload, 4-state logic.
in_last  input  1  final beat of the frame.
out_valid  output  1  frame available.
out_ready  input  1  consumer takes frame when out_valid && out_ready.
out_go  output  BEATS*BEAT_W  frame; bits [35:24]=go[2] (beat 0), [23:12]=go[1], [11:0]=go[0].
out_ts  output  TS_W  cycle-counter value at acceptance of the frame's beat 0.
out_xz  output  1  any bit of out_go is X or Z.
out_err  output  1  frame was short (padded) or long (truncated).
frame_cnt  output  CNT_W  frames delivered (handshakes on output), wraps.

Behaviour:
- Reset (sync, rst=1 at edge): out_valid=0, out_go=0, out_ts=0, out_xz=0, out_err=0, frame_cnt=0, cycle counter=0, beat index=0, FSM=FILL. Staged beats discarded. Reset mid-frame drops the partial frame and sends no output.
- Cycle counter: free-running, +1 every non-reset cycle, wraps 2^64-1 -> 0.
- FSM states: FILL, STALL, DISCARD. in_ready = (state != STALL). This is combinational from state only and never depends on out_ready.
- FILL, beat accepted at index i:
  - Store into staging slot i. If i==0, capture the ts.
  - in_last && i<2: short frame. Pad remaining slots with 0, set err, frame complete.
  - i==2 && in_last: frame complete, err=0.
  - i==2 && !in_last: long frame. Set err, frame complete, then go to DISCARD.
  - Otherwise: i <= i+1.
- Frame complete: if output register free (out_valid==0 or out_ready==1 this cycle), load out_go/out_ts/out_err and out_xz (= $isunknown over the staged frame) next cycle with out_valid=1, then i<=0 and next state FILL (or DISCARD). Else go to STALL holding the staged frame.
- STALL: on the first cycle with out_ready=1, transfer the frame to the output register, then return to FILL (or DISCARD if pending long frame; remember this with a flag).
- DISCARD: in_ready=1, beats consumed and dropped, frame complete ignored. On an accepted beat with in_last=1, return to FILL, i=0. The discard wait may overlap the STALL of the truncated frame. The discard flag survives STALL.
- Latency: last beat accepted at cycle N, out_valid=1 at N+1 when the output register is free. Minimum throughput is one frame per 3 cycles, with no bubble on back-to-back frames.
- Simultaneous output handshake and frame completion in the same cycle: new frame loads, out_valid stays 1, and frame_cnt increments once.
- out_valid falls only on a handshake with no replacement frame. Output fields are stable while out_valid && !out_ready.
- frame_cnt increments on each output handshake and wraps 0xFFFF -> 0.
- X/Z on in_valid/out_ready is not supported. X/Z in in_data is carried through unchanged and reported via out_xz.

Decomposition:
- Package go_frame_pkg:
  - constants BEATS, BEAT_W, TS_W.
  - typedef logic [0:3][0:2][3:3] go_beat_t.
  - typedef go_beat_t go_frame_t [2:0].
  - typedef enum {FILL, STALL, DISCARD} asm_state_e.
- One sub-module, go_ts_counter: the free-running TS_W counter with sync reset. Everything else stays in go_frame_assembler.

Test Plan:
- Back-to-back frames with out_ready=1: beats 0x111,0x222,0x333 then 0x444,0x555,0x666 (last on 3rd) -> out_go=0x111222333 at cycle 4, 0x444555666 at cycle 7; frame_cnt=2; out_err=0.
- Short frame: 0xABC, 0xDEF with in_last on beat 1 -> out_go=0xABCDEF000, out_err=1.
- Long frame: 5 beats 0x001..0x005, last on beat 5 -> out_go=0x001002003, out_err=1; beats 4-5 dropped; next frame 0x00A,0x00B,0x00C delivers cleanly.
- Backpressure: out_ready=0 for 10 cycles while 2 frames are sent -> first frame held stable on output, second in STALL with in_ready=0; release out_ready -> both delivered in order, no loss.
- X/Z: beat 1 = 12'b0000_x000_z000 -> out_xz=1, X/Z bits preserved in out_go[23:12]; following all-0/1 frame gives out_xz=0.
- Reset mid-frame after 2 beats, then a full frame 0x777,0x888,0x999 -> only 0x777888999 delivered, out_ts equals the counter value counted from reset.
